// File: rtl/prim_shadow_wr_ctrl_pkg.sv
// prim_shadow_wr_ctrl_pkg: shared FSM state and result-code types for the shadowed-register write controller
// Contents: state_e (controller FSM), err_e (rsp_err_o codes), idx_w() (index width, min 1)
package prim_shadow_wr_ctrl_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_WR1, ST_WR2, ST_CHECK, ST_RESP} state_e;
    typedef enum logic [1:0] {ERR_OK, ERR_UPDATE, ERR_STORAGE, ERR_READBACK} err_e;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/prim_shadow_wr_ctrl_if.sv
// prim_shadow_wr_ctrl_if: requester and shadowed-register signals of the write controller
// Requester side: req_valid_i, req_wd_i -> req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o
// Register side: shadow_re_o, shadow_we_o, shadow_wd_o -> shadow_q_i, shadow_err_update_i, shadow_err_storage_i
// Modports: master (requesters plus register model), slave (controller)
interface prim_shadow_wr_ctrl_if import prim_shadow_wr_ctrl_pkg::*; #(
    parameter int NumReq = 2,
    parameter int DW = 32
);
    localparam int IdW = idx_w(NumReq);
    logic [NumReq-1:0] req_valid_i;
    logic [NumReq-1:0][DW-1:0] req_wd_i;
    logic [NumReq-1:0] req_ready_o;
    logic rsp_valid_o;
    logic [IdW-1:0] rsp_id_o;
    logic [1:0] rsp_err_o;
    logic shadow_re_o;
    logic shadow_we_o;
    logic [DW-1:0] shadow_wd_o;
    logic [DW-1:0] shadow_q_i;
    logic shadow_err_update_i;
    logic shadow_err_storage_i;
    modport master (
        output req_valid_i, req_wd_i, shadow_q_i, shadow_err_update_i, shadow_err_storage_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o, shadow_re_o, shadow_we_o, shadow_wd_o
    );
    modport slave (
        input  req_valid_i, req_wd_i, shadow_q_i, shadow_err_update_i, shadow_err_storage_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o, shadow_re_o, shadow_we_o, shadow_wd_o
    );
endinterface

// File: rtl/prim_shadow_wr_rr_arb.sv
// prim_shadow_wr_rr_arb: round-robin pick of the first requester at or after ptr_i
// Ports: req_i (requests), ptr_i (priority pointer) -> gnt_o (one-hot grant), idx_o (granted index)
module prim_shadow_wr_rr_arb import prim_shadow_wr_ctrl_pkg::*; #(
    parameter int NumReq = 2,
    localparam int IdW = idx_w(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdW-1:0]    ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdW-1:0]    idx_o
);
    // Scanning from the farthest offset down leaves the nearest requester to ptr_i in idx_o.
    always_comb begin
        idx_o = '0;
        for (int i = NumReq - 1; i >= 0; i--)
            if (req_i[(int'(ptr_i) + i) % NumReq]) idx_o = IdW'((int'(ptr_i) + i) % NumReq);
        gnt_o = |req_i ? NumReq'(1) << idx_o : '0;
    end
endmodule

// File: rtl/prim_shadow_wr_ctrl.sv
// prim_shadow_wr_ctrl: arbitrates requesters and runs the clear/write/write(/check) sequence on a shadowed register
// Ports: clk_i, rst_ni (async, active-low); bus (prim_shadow_wr_ctrl_if.slave);
//        busy_o (transaction in flight), fatal_o (sticky storage error)
// Option: PRIM_SHADOW_WR_CTRL_READBACK_EN adds a CHECK state comparing shadow_q_i against the written data.
module prim_shadow_wr_ctrl import prim_shadow_wr_ctrl_pkg::*; #(
    parameter int NumReq = 2,
    parameter int DW = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    prim_shadow_wr_ctrl_if.slave bus,
    output logic busy_o,
    output logic fatal_o
);
    localparam int IdW = idx_w(NumReq);
    state_e state_q, state_d;
    err_e err_q, err_d;
    logic [IdW-1:0] ptr_q, id_q, gnt_idx;
    logic [DW-1:0] data_q;
    logic [NumReq-1:0] gnt;
    logic fatal_q, grant;
    prim_shadow_wr_rr_arb #(.NumReq(NumReq)) u_arb (
        .req_i(bus.req_valid_i),
        .ptr_i(ptr_q),
        .gnt_o(gnt),
        .idx_o(gnt_idx)
    );
    // rst_ni gates the grant so req_ready_o stays low while reset is held.
    assign grant = rst_ni && state_q == ST_IDLE && |bus.req_valid_i;
    always_comb begin
        state_d = state_q;
        err_d = err_q;
        case (state_q)
            ST_IDLE: if (grant) begin
                state_d = fatal_q ? ST_RESP : ST_CLEAR;
                err_d = fatal_q ? ERR_STORAGE : ERR_OK;
            end
            ST_CLEAR: state_d = ST_WR1;
            ST_WR1: state_d = ST_WR2;
            ST_WR2: begin
`ifdef PRIM_SHADOW_WR_CTRL_READBACK_EN
                state_d = ST_CHECK;
`else
                state_d = ST_RESP;
`endif
                if (bus.shadow_err_update_i && err_q == ERR_OK) err_d = ERR_UPDATE;
            end
`ifdef PRIM_SHADOW_WR_CTRL_READBACK_EN
            ST_CHECK: begin
                state_d = ST_RESP;
                if (bus.shadow_q_i != data_q && err_q == ERR_OK) err_d = ERR_READBACK;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (bus.shadow_err_storage_i) err_d = ERR_STORAGE;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            err_q <= ERR_OK;
            ptr_q <= '0;
            id_q <= '0;
            data_q <= '0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q <= err_d;
            fatal_q <= fatal_q | bus.shadow_err_storage_i;
            if (grant) begin
                ptr_q <= (gnt_idx == IdW'(NumReq - 1)) ? '0 : gnt_idx + IdW'(1);
                id_q <= gnt_idx;
                data_q <= bus.req_wd_i[gnt_idx];
            end
        end
    end
    assign bus.req_ready_o = grant ? gnt : '0;
    assign bus.shadow_re_o = state_q == ST_CLEAR;
    assign bus.shadow_we_o = state_q == ST_WR1 || state_q == ST_WR2;
    assign bus.shadow_wd_o = bus.shadow_we_o ? data_q : '0;
    assign bus.rsp_valid_o = state_q == ST_RESP;
    assign bus.rsp_id_o = bus.rsp_valid_o ? id_q : '0;
    assign bus.rsp_err_o = bus.rsp_valid_o ? err_q : ERR_OK;
    assign busy_o = state_q != ST_IDLE;
    assign fatal_o = fatal_q;
endmodule

// File: tb/tb_prim_shadow_wr_ctrl.sv
// tb_prim_shadow_wr_ctrl: directed self-checking bench for prim_shadow_wr_ctrl (NumReq=2, DW=32)
module tb_prim_shadow_wr_ctrl;
`ifdef PRIM_SHADOW_WR_CTRL_READBACK_EN
    localparam logic [1:0] RbErr = 2'd3;
`else
    localparam logic [1:0] RbErr = 2'd0;
`endif
    logic clk, rst_n, busy, fatal;
    int checks = 0;
    int errors = 0;
    prim_shadow_wr_ctrl_if #(.NumReq(2), .DW(32)) bus ();
    prim_shadow_wr_ctrl #(.NumReq(2), .DW(32)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus(bus.slave),
        .busy_o(busy),
        .fatal_o(fatal)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // One full non-fatal transaction, entered and left at a falling edge with the controller idle.
    task automatic txn(input string tag, input logic [1:0] vld, input logic [31:0] d0, input logic [31:0] d1,
                       input int gid, input logic upd, input logic sto, input logic [31:0] q,
                       input logic [1:0] err, input logic hold);
        logic [31:0] d;
        d = (gid == 0) ? d0 : d1;
        bus.req_valid_i = vld;
        bus.req_wd_i[0] = d0;
        bus.req_wd_i[1] = d1;
        #1;
        chk({tag, ".gnt"}, 32'(bus.req_ready_o), 32'(1) << gid);
        @(negedge clk);
        if (!hold) bus.req_valid_i = '0;
        bus.req_wd_i = '0;
        chk({tag, ".clr"}, 32'({bus.shadow_re_o, bus.shadow_we_o, busy, bus.rsp_valid_o}), 32'b1010);
        chk({tag, ".clr_wd"}, bus.shadow_wd_o, 32'h0);
        @(negedge clk);
        bus.shadow_err_storage_i = sto;
        chk({tag, ".wr1"}, 32'({bus.shadow_re_o, bus.shadow_we_o}), 32'b01);
        chk({tag, ".wr1_wd"}, bus.shadow_wd_o, d);
        @(negedge clk);
        bus.shadow_err_storage_i = 1'b0;
        bus.shadow_err_update_i = upd;
        chk({tag, ".wr2"}, 32'({bus.shadow_re_o, bus.shadow_we_o, bus.rsp_valid_o}), 32'b010);
        chk({tag, ".wr2_wd"}, bus.shadow_wd_o, d);
        @(negedge clk);
        bus.shadow_err_update_i = 1'b0;
        bus.shadow_q_i = q;
`ifdef PRIM_SHADOW_WR_CTRL_READBACK_EN
        chk({tag, ".check"}, 32'({bus.rsp_valid_o, bus.shadow_we_o, busy}), 32'b001);
        @(negedge clk);
`endif
        chk({tag, ".rsp"}, 32'({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_err_o}), 32'({1'b1, 1'(gid), err}));
        @(negedge clk);
        chk({tag, ".done"}, 32'({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_err_o, busy, bus.shadow_we_o}), 32'h0);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
    initial begin
        rst_n = 1'b0;
        bus.req_valid_i = '0;
        bus.req_wd_i = '0;
        bus.shadow_q_i = '0;
        bus.shadow_err_update_i = 1'b0;
        bus.shadow_err_storage_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.outs", 32'({busy, fatal, bus.req_ready_o, bus.rsp_valid_o, bus.shadow_re_o, bus.shadow_we_o}), 32'h0);
        chk("rst.wd", bus.shadow_wd_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        txn("basic", 2'b01, 32'hA5A5_0001, 32'h0, 0, 1'b0, 1'b0, 32'hA5A5_0001, 2'd0, 1'b0);
        do_reset();
        txn("rr0", 2'b11, 32'h1111_0000, 32'h2222_0000, 0, 1'b0, 1'b0, 32'h1111_0000, 2'd0, 1'b1);
        txn("rr1", 2'b11, 32'h1111_0001, 32'h2222_0001, 1, 1'b0, 1'b0, 32'h2222_0001, 2'd0, 1'b1);
        txn("rr2", 2'b11, 32'h1111_0002, 32'h2222_0002, 0, 1'b0, 1'b0, 32'h1111_0002, 2'd0, 1'b1);
        txn("rr3", 2'b11, 32'h1111_0003, 32'h2222_0003, 1, 1'b0, 1'b0, 32'h2222_0003, 2'd0, 1'b0);
        txn("upd", 2'b01, 32'h0000_0055, 32'h0, 0, 1'b1, 1'b0, 32'h0000_0055, 2'd1, 1'b0);
        chk("upd.fatal", 32'(fatal), 32'h0);
        txn("upd_next", 2'b10, 32'h0, 32'h0000_0066, 1, 1'b0, 1'b0, 32'h0000_0066, 2'd0, 1'b0);
        txn("rb", 2'b01, 32'h0000_1234, 32'h0, 0, 1'b0, 1'b0, 32'h0, RbErr, 1'b0);
        txn("sto", 2'b01, 32'hDEAD_0000, 32'h0, 0, 1'b0, 1'b1, 32'hDEAD_0000, 2'd2, 1'b0);
        chk("sto.fatal", 32'(fatal), 32'h1);
        bus.req_valid_i = 2'b10;
        bus.req_wd_i[1] = 32'hCAFE_0000;
        #1;
        chk("fat.gnt", 32'(bus.req_ready_o), 32'b10);
        @(negedge clk);
        bus.req_valid_i = '0;
        chk("fat.rsp", 32'({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_err_o, bus.shadow_re_o, bus.shadow_we_o}), 32'b1_1_10_00);
        @(negedge clk);
        chk("fat.done", 32'({bus.rsp_valid_o, busy, fatal, bus.shadow_re_o, bus.shadow_we_o}), 32'b00100);
        do_reset();
        chk("rst2.fatal", 32'(fatal), 32'h0);
        bus.req_valid_i = 2'b01;
        bus.req_wd_i[0] = 32'h0000_BEEF;
        #1;
        chk("mid.gnt", 32'(bus.req_ready_o), 32'b01);
        @(negedge clk);
        bus.shadow_err_storage_i = 1'b1;
        @(negedge clk);
        bus.shadow_err_storage_i = 1'b0;
        chk("mid.wr1", 32'({bus.shadow_we_o, fatal}), 32'b11);
        rst_n = 1'b0;
        #1;
        chk("mid.rst", 32'({busy, fatal, bus.shadow_we_o, bus.shadow_re_o, bus.rsp_valid_o, bus.req_ready_o}), 32'h0);
        chk("mid.rst_wd", bus.shadow_wd_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        txn("regrant", 2'b01, 32'h0000_BEEF, 32'h0, 0, 1'b0, 1'b0, 32'h0000_BEEF, 2'd0, 1'b0);
        chk("end.fatal", 32'(fatal), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
